instruction_fetch: RTL and testbench
====================================

# instruction_fetch

IF stage of the 5-stage MIPS pipeline. It holds the program counter and the instruction memory, and selects the next PC from sequential, branch and jump sources. It produces the incremented PC and the fetched instruction that the IF/ID pipeline latch registers on the next `clk` edge. It also detects the HALT word, freezes fetch, and counts fetches for the debug unit.

## Interface
- `B`, 32, datapath width: PC, instruction, targets.
- `ADDR_W`, 7, instruction-memory word-address width (2^ADDR_W words).
- `HALT_WORD`, 32'hFFFF_FFFF, encoding that stops fetch.

Ports:
- `clk` in 1: single clock, all state on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `stall` in 1: hazard unit hold request (load-use).
- `branch_taken` in 1: taken branch resolved downstream.
- `branch_target` in B: branch destination byte address.
- `jump` in 1: jump resolved downstream.
- `jump_target` in B: jump destination byte address.
- `mem_we` in 1: program-load write enable.
- `mem_waddr` in ADDR_W: program-load word address.
- `mem_wdata` in B: program-load word.
- `pc_incrementado` out B: PC+4 of the current fetch, combinational from the PC.
- `instruction` out B: fetched word; NOP (0) while halted.
- `pc` out B: current PC register.
- `halted` out 1: fetch frozen on HALT.
- `fetch_count` out B: number of PC advances since reset, saturating.

## Operation
- Memory read is asynchronous: `instruction = mem[pc[ADDR_W+1:2]]`. PC bits [1:0] are ignored. Addresses above the memory size alias by truncation.
- Memory write is synchronous on posedge when `mem_we`=1. The write is independent of fetch state.
- Next-PC priority per edge, highest first:
  - `!rst_n`: PC=0.
  - `jump`: PC=jump_target.
  - `branch_taken`: PC=branch_target.
  - `halted` or `stall`: PC held.
  - Current word == HALT_WORD: PC held and `halted` set.
  - Otherwise: PC=PC+4.
- Redirects (jump/branch) override `stall`, because they come from an older instruction.
- A redirect clears `halted`. A HALT fetched on a wrong path therefore never sticks.
- A HALT fetched in the same cycle as a redirect is ignored. `halted` stays 0.
- PC+4 is modulo 2^B. All-ones + 4 wraps to 3.
- `fetch_count` increments on every edge where PC changes source to sequential or redirect. It does not increment on hold, stall or halt. It saturates at 2^B-1.
- While `halted`=1: `instruction`=0 (NOP). `pc_incrementado` continues to reflect the held PC+4.

## Timing
- Reset values: pc=0, halted=0, fetch_count=0. Consequently pc_incrementado=4 and instruction=mem[0] after reset.
- Memory contents are not reset.
- Latency: a redirect asserted in cycle n gives pc=target in cycle n+1, with its word on `instruction` in the same cycle n+1. The target word reaches the ID stage at n+2.
- `stall` is level-sensitive. The PC holds for every cycle it is high, and outputs remain stable.
- Reset mid-operation: on the first edge with rst_n=0, all state returns to reset values regardless of stall, redirect or halt.
- A write to the address currently being fetched shows the new word only after the write edge. There is no bypass.

## Structure
- Shared package/include `mips_defs`: `HALT_WORD`, `NOP_WORD`=0, `PC_INC`=4, and the instruction width constant shared with the IF/ID latch.
- One sub-module, `instruction_memory`: 1 async read port, 1 sync write port, depth 2^ADDR_W.
- The PC register, next-PC mux, halt flag and counter live in `instruction_fetch`.

## Test plan
- Reset, then load words 0x20010005, 0x20020007, 0xFFFFFFFF at addresses 0..2.
  - Free-run: pc goes 0, 4, 8 and then holds at 8.
  - `halted`=1 from the cycle after pc=8.
  - `instruction`=0 while halted; fetch_count=2.
- Stall held high for 3 cycles at pc=4: pc stays 4, outputs stay stable, fetch_count unchanged. Release gives pc=8 next edge.
- Assert stall=1, branch_taken=1 and branch_target=0x40 in the same cycle: next pc=0x40 (redirect wins).
  - Also assert jump=1 (jump_target=0x10) and branch_taken=1 (target 0x40) together: pc=0x10.
- Halted at pc=8, then jump to 0x0C: halted=0 and pc=0x0C next cycle. Sequential fetch resumes with pc=0x10 after that.
- Reset asserted while halted with fetch_count=5: next edge gives pc=0, halted=0, fetch_count=0, pc_incrementado=4.
- Force pc=0x200 via jump with ADDR_W=7: instruction=mem[0] (alias).
  - Separately, jump to 0xFFFFFFFC: next sequential pc=0 (wrap).

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS pipeline constants.
//   INSTR_W   : instruction width, shared with the IF/ID latch
//   HALT_WORD : encoding that freezes fetch
//   NOP_WORD  : word issued downstream while fetch is frozen
//   PC_INC    : sequential PC step in bytes
package mips_defs;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [INSTR_W-1:0] NOP_WORD  = '0;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/instruction_memory.sv
// Instruction memory: one asynchronous read port, one synchronous write port.
// Contents are not reset.
// Ports:
//   clk   : write clock
//   we    : write enable (program load)
//   waddr : write word address
//   wdata : write data
//   raddr : read word address
//   rdata : read data, combinational from raddr
module instruction_memory #(
  parameter int unsigned Width = 32,
  parameter int unsigned AddrW = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [2**AddrW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // No write bypass: a word written this edge is visible from the next cycle.
  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: program counter, next-PC selection, halt detection and fetch counter.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   stall                       : hazard-unit hold request
//   branch_taken, branch_target : taken-branch redirect
//   jump, jump_target           : jump redirect (wins over branch)
//   mem_we, mem_waddr, mem_wdata: program-load write port
//   pc_incrementado             : pc + 4 (wraps modulo 2^B)
//   instruction                 : fetched word, NOP while halted
//   pc                          : current PC register
//   halted                      : fetch frozen on HALT word
//   fetch_count                 : saturating count of PC advances since reset
module instruction_fetch import mips_defs::*; #(
  parameter int unsigned     B         = INSTR_W,
  parameter int unsigned     ADDR_W    = 7,
  parameter logic [B-1:0]    HALT_WORD = mips_defs::HALT_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [B-1:0]      branch_target,
  input  logic              jump,
  input  logic [B-1:0]      jump_target,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [B-1:0]      mem_wdata,
  output logic [B-1:0]      pc_incrementado,
  output logic [B-1:0]      instruction,
  output logic [B-1:0]      pc,
  output logic              halted,
  output logic [B-1:0]      fetch_count
);

  logic [B-1:0] pc_q, pc_d;
  logic         halted_q, halted_d;
  logic [B-1:0] fetch_count_q, fetch_count_d;
  logic [B-1:0] mem_word;
  logic         advance;

  instruction_memory #(
    .Width (B),
    .AddrW (ADDR_W)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (pc_q[ADDR_W+1:2]),
    .rdata (mem_word)
  );

  assign pc_incrementado = pc_q + B'(PC_INC);

  // Redirects come from older instructions, so they beat stall and clear halt.
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    advance  = 1'b0;
    if (jump) begin
      pc_d     = jump_target;
      halted_d = 1'b0;
      advance  = 1'b1;
    end else if (branch_taken) begin
      pc_d     = branch_target;
      halted_d = 1'b0;
      advance  = 1'b1;
    end else if (halted_q || stall) begin
      pc_d = pc_q;
    end else if (mem_word == HALT_WORD) begin
      halted_d = 1'b1;
    end else begin
      pc_d    = pc_incrementado;
      advance = 1'b1;
    end
  end

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (advance && (fetch_count_q != '1)) begin
      fetch_count_d = fetch_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= '0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc          = pc_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;
  assign instruction = halted_q ? B'(NOP_WORD) : mem_word;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam int unsigned Depth = 128;
  localparam logic [31:0] Halt  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        mem_we;
  logic [6:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] pc_incrementado;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        halted;
  logic [31:0] fetch_count;

  instruction_fetch #(
    .B      (32),
    .ADDR_W (7)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jump            (jump),
    .jump_target     (jump_target),
    .mem_we          (mem_we),
    .mem_waddr       (mem_waddr),
    .mem_wdata       (mem_wdata),
    .pc_incrementado (pc_incrementado),
    .instruction     (instruction),
    .pc              (pc),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        halted;
    logic [31:0] cnt;
    logic [31:0] instr;
    logic        instr_known;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state: architectural view, one entry per word address.
  logic [31:0] m_pc;
  logic        m_halted;
  logic [31:0] m_cnt;
  logic [31:0] m_mem   [Depth];
  bit          m_known [Depth];

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % Depth);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: DUT presents a fresh fetch every cycle; compare just after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc", pc, e.pc);
      chk("halted", {31'b0, halted}, {31'b0, e.halted});
      chk("fetch_count", fetch_count, e.cnt);
      chk("pc_incrementado", pc_incrementado, e.pc + 32'd4);
      if (e.instr_known) chk("instruction", instruction, e.instr);
    end
  end

  // Drive one cycle of inputs, advance the model across the coming edge, queue expectation.
  task automatic step(input bit r, input bit st, input bit br, input logic [31:0] bt,
                      input bit j, input logic [31:0] jt, input bit we,
                      input logic [6:0] wa, input logic [31:0] wd);
    logic [31:0] cur;
    bit          cur_known;
    bit          moved;
    exp_t        e;
    @(negedge clk);
    rst_n = r; stall = st; branch_taken = br; branch_target = bt;
    jump = j; jump_target = jt; mem_we = we; mem_waddr = wa; mem_wdata = wd;

    cur       = m_mem[widx(m_pc)];
    cur_known = m_known[widx(m_pc)];
    moved     = 1'b0;
    if (!r) begin
      m_pc = 0; m_halted = 0; m_cnt = 0;
    end else if (j) begin
      m_pc = jt; m_halted = 0; moved = 1;
    end else if (br) begin
      m_pc = bt; m_halted = 0; moved = 1;
    end else if (m_halted || st) begin
      // hold
    end else if (cur_known && cur == Halt) begin
      m_halted = 1;
    end else begin
      m_pc = m_pc + 32'd4; moved = 1;
    end
    if (moved && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (we) begin
      m_mem[int'(wa)]   = wd;
      m_known[int'(wa)] = 1'b1;
    end

    e.pc          = m_pc;
    e.halted      = m_halted;
    e.cnt         = m_cnt;
    e.instr       = m_halted ? 32'h0 : m_mem[widx(m_pc)];
    e.instr_known = m_halted || m_known[widx(m_pc)];
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jmp(input logic [31:0] t);
    step(1, 0, 0, 0, 1, t, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom();
    if (w == Halt) w = 32'h0;
    return w;
  endfunction

  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'h2001_0005;
    prog[1] = 32'h2002_0007;
    prog[2] = Halt;
    m_pc = 0; m_halted = 0; m_cnt = 0;
    for (int i = 0; i < Depth; i++) m_known[i] = 1'b0;
    rst_n = 0; stall = 0; branch_taken = 0; branch_target = 0;
    jump = 0; jump_target = 0; mem_we = 0; mem_waddr = 0; mem_wdata = 0;

    // Reset with memory still unloaded.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Program load while held in reset.
    for (int i = 0; i < Depth; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 7'(i), (i < 3) ? prog[i] : rand_word());
    end
    // Free-run into HALT at pc=8.
    run(6);
    // Jump out of halt, sequential fetch resumes.
    jmp(32'h0C);
    run(2);
    // Stall three cycles at pc=4, then release.
    jmp(32'h04);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    run(3);
    // Redirect beats stall; jump beats branch.
    step(1, 1, 1, 32'h40, 0, 0, 0, 0, 0);
    step(1, 0, 1, 32'h40, 1, 32'h10, 0, 0, 0);
    run(1);
    // Reach halt with fetch_count=5, then reset.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run(3);
    jmp(32'h00);
    run(4);
    step(0, 1, 1, 32'h40, 0, 0, 0, 0, 0);
    // Address aliasing and PC wrap.
    jmp(32'h200);
    run(1);
    jmp(32'hFFFF_FFFC);
    run(1);
    jmp(32'hFFFF_FFFF);
    // Overwrite the word being fetched: visible only after the write edge.
    jmp(32'h20);
    step(1, 1, 0, 0, 0, 0, 1, 7'd8, 32'h1234_5678);
    step(1, 1, 0, 0, 0, 0, 1, 7'd8, Halt);
    run(2);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      bit          r, st, br, j, we;
      logic [31:0] bt, jt, wd;
      logic [6:0]  wa;
      r  = ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 7) == 0);
      j  = ($urandom_range(0, 9) == 0);
      bt = ($urandom_range(0, 15) == 0) ? $urandom() : {23'b0, 7'($urandom_range(0, 127)), 2'b00};
      jt = ($urandom_range(0, 15) == 0) ? $urandom() : {23'b0, 7'($urandom_range(0, 127)), 2'b00};
      we = ($urandom_range(0, 3) == 0);
      wa = ($urandom_range(0, 1) == 0) ? 7'(widx(m_pc)) : 7'($urandom_range(0, 127));
      wd = ($urandom_range(0, 5) == 0) ? Halt : rand_word();
      step(r, st, br, bt, j, jt, we, wa, wd);
    end

    @(negedge clk);
    mem_we = 0; jump = 0; branch_taken = 0; stall = 0;
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
